// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the round-robin comparator arbiter.
// Holds the FSM state enum, default sizes and the round-robin winner search.
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;
  localparam int NREQ_MAX = 8;
  localparam int IDW_MAX  = 3;

  // First set request at or above ptr, wrapping at nreq; -1 when nothing is requested.
  function automatic int rr_pick(input logic [NREQ_MAX-1:0] req, input int ptr, input int nreq);
    int win;
    int idx;
    win = -1;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = (ptr + k) % nreq;
      if (k < nreq && win < 0 && req[idx[IDW_MAX-1:0]]) begin
        win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mag_cmp_arbiter_if.sv
// Requester-side bundle of the comparator arbiter: level requests and operands in,
// grant/done/result flags out. master = requesters, slave = arbiter.
interface mag_cmp_arbiter_if
  import mag_cmp_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opa;
  logic [NREQ*W-1:0] opb;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              res_eq;
  logic              res_gt;
  logic              res_lt;
  logic [IDW-1:0]    res_id;
  logic              busy;

  modport master (
    output req, opa, opb,
    input  gnt, done, res_eq, res_gt, res_lt, res_id, busy
  );

  modport slave (
    input  req, opa, opb,
    output gnt, done, res_eq, res_gt, res_lt, res_id, busy
  );

endinterface

// File: rtl/mag_cmp_core.sv
// Unsigned W-bit magnitude comparator; purely combinational, zero latency.
// No handshake: outputs follow a/b within the same cycle.
module mag_cmp_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_arbiter.sv
// Round-robin scheduler sharing one comparator: gnt in t+1, done/results in t+2 after req.
// No backpressure: requesters hold req/operands until gnt; one comparison per 3 cycles.
module mag_cmp_arbiter
  import mag_cmp_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mag_cmp_arbiter_if.slave  bus
);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [IDW-1:0] win;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic           cmp_eq;
  logic           cmp_gt;
  logic           cmp_lt;
  int             pick;

  always_comb begin
    pick = rr_pick(NREQ_MAX'(bus.req), int'(rr_ptr), NREQ);
  end

  assign win = IDW'(pick);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel = bus.opa[i*W +: W];
        b_sel = bus.opb[i*W +: W];
      end
    end
  end

  mag_cmp_core #(.W(W)) u_core (
    .a  (a_r),
    .b  (b_r),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      bus.gnt    <= '0;
      bus.done   <= '0;
      bus.res_eq <= 1'b0;
      bus.res_gt <= 1'b0;
      bus.res_lt <= 1'b0;
      bus.res_id <= '0;
      bus.busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            a_r      <= a_sel;
            b_r      <= b_sel;
            id_r     <= win;
            bus.gnt  <= NREQ'(1) << win;
            bus.busy <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          bus.res_eq <= cmp_eq;
          bus.res_gt <= cmp_gt;
          bus.res_lt <= cmp_lt;
          bus.res_id <= id_r;
          bus.done   <= NREQ'(1) << id_r;
          bus.gnt    <= '0;
          // The just-served requester drops to lowest priority.
          rr_ptr     <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + 1'b1;
          state      <= DONE;
        end
        DONE: begin
          bus.done <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mag_cmp_arbiter.sv
// Randomized + directed bench for mag_cmp_arbiter against a transaction-level model.
module tb_mag_cmp_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mag_cmp_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  mag_cmp_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: round-robin pointer and the result currently held.
  int         ptr = 0;
  logic [W-1:0] a [NREQ];
  logic [W-1:0] b [NREQ];
  int exp_eq = 0;
  int exp_gt = 0;
  int exp_lt = 0;
  int exp_id = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.opa[i*W +: W] = a[i];
      bus.opb[i*W +: W] = b[i];
    end
  endtask

  task automatic check_all(input string tag, input int g, input int d, input int bz);
    check({tag, ".gnt"},    int'(bus.gnt),    g);
    check({tag, ".done"},   int'(bus.done),   d);
    check({tag, ".busy"},   int'(bus.busy),   bz);
    check({tag, ".res_eq"}, int'(bus.res_eq), exp_eq);
    check({tag, ".res_gt"}, int'(bus.res_gt), exp_gt);
    check({tag, ".res_lt"}, int'(bus.res_lt), exp_lt);
    check({tag, ".res_id"}, int'(bus.res_id), exp_id);
  endtask

  function automatic int pick_winner(input logic [NREQ-1:0] rq);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (rq[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Called with the DUT about to sample in IDLE; returns with it back in IDLE.
  task automatic run_txn(input string tag, input logic [NREQ-1:0] rq, input bit mutate, input bit drop);
    int           wi;
    logic [1:0]   w;
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    bus.req = rq;
    drive_ops();
    if (rq == '0) begin
      tick();
      check_all({tag, ".noreq"}, 0, 0, 0);
      return;
    end
    wi = pick_winner(rq);
    w  = wi[1:0];
    ca = a[w];
    cb = b[w];
    tick();
    check_all({tag, ".grant"}, 1 << w, 0, 1);
    if (mutate) begin
      a[w] = ~a[w];
      b[w] = ~b[w];
      drive_ops();
    end
    if (drop) bus.req = '0;
    tick();
    exp_eq = (ca == cb) ? 1 : 0;
    exp_gt = (ca > cb) ? 1 : 0;
    exp_lt = (ca < cb) ? 1 : 0;
    exp_id = wi;
    ptr    = (wi + 1) % NREQ;
    check_all({tag, ".done"}, 0, 1 << w, 1);
    tick();
    check_all({tag, ".idle"}, 0, 0, 0);
  endtask

  task automatic set_ops(input int i, input int av, input int bv);
    a[i] = W'(av);
    b[i] = W'(bv);
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 0, 0);
    drive_ops();
    tick();
    tick();
    check_all("reset", 0, 0, 0);
    rst_n = 1'b1;

    set_ops(0, 5, 5);
    run_txn("single", 4'b0001, 1'b0, 1'b1);

    set_ops(2, 12, 3);
    run_txn("r2_gt", 4'b0100, 1'b0, 1'b1);
    set_ops(2, 0, 15);
    run_txn("r2_lt", 4'b0100, 1'b0, 1'b1);

    bus.req = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_all("idle_hold", 0, 0, 0);
    end

    set_ops(2, 15, 15);
    run_txn("r2_eq", 4'b0100, 1'b0, 1'b1);

    set_ops(3, 1, 1);
    run_txn("align", 4'b1000, 1'b0, 1'b1);
    set_ops(0, 3, 3);
    set_ops(1, 7, 2);
    set_ops(2, 10, 11);
    set_ops(3, 9, 6);
    for (int t = 0; t < 5; t++) run_txn("contend", 4'b1111, 1'b0, 1'b0);

    set_ops(1, 9, 4);
    run_txn("late_change", 4'b0010, 1'b1, 1'b0);

    // Abort a transaction in its CMP cycle.
    set_ops(1, 3, 8);
    bus.req = 4'b0010;
    drive_ops();
    tick();
    check_all("abort.grant", 2, 0, 1);
    rst_n   = 1'b0;
    bus.req = '0;
    tick();
    exp_eq = 0;
    exp_gt = 0;
    exp_lt = 0;
    exp_id = 0;
    ptr    = 0;
    check_all("abort.reset", 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_all("abort.after", 0, 0, 0);
    set_ops(0, 4, 4);
    set_ops(3, 2, 13);
    run_txn("post_reset", 4'b1001, 1'b0, 1'b0);
    run_txn("post_reset3", 4'b1000, 1'b0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
      run_txn("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mag_cmp_arbiter.md
Name: mag_cmp_arbiter

Overview:
- Round-robin scheduler that shares one W-bit magnitude comparator (equal / greater / less) between NREQ requesters.
- Arbitrates level requests, latches the winner's operand pair and runs the shared comparator for one cycle.
- Returns registered eq/gt/lt flags plus the served requester ID, with a one-cycle done pulse to that requester.
- Sits between the board-level switch/input logic and the LED result outputs. It replaces per-requester comparator copies.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width in bits
- IDW, 2, width of requester ID; must equal ceil(log2(NREQ))

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req  input  NREQ  level request, one bit per requester
- opa  input  NREQ*W  operand A; requester i uses bits [i*W +: W]
- opb  input  NREQ*W  operand B; requester i uses bits [i*W +: W]
- gnt  output  NREQ  one-hot grant; high while the granted operands are being compared
- done  output  NREQ  one-hot, one-cycle pulse; result valid for that requester
- res_eq  output  1  registered A==B
- res_gt  output  1  registered A>B
- res_lt  output  1  registered A<B
- res_id  output  IDW  ID of the requester owning the current result
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: state=IDLE, gnt=0, done=0, res_eq=0, res_gt=0, res_lt=0, res_id=0, busy=0, rr_ptr=0.
- Reset mid-transaction aborts the transaction. No done pulse is issued.
- FSM has three states: IDLE, CMP, DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the winner: the first set req bit searching upward from rr_ptr, wrapping NREQ-1 -> 0.
  - At the edge: a_r <= opa[win], b_r <= opb[win], id_r <= win, gnt <= onehot(win), state -> CMP.
- CMP:
  - The comparator evaluates a_r vs b_r combinationally.
  - At the edge: res_eq/gt/lt <= comparator outputs, res_id <= id_r, done <= onehot(id_r), gnt <= 0, rr_ptr <= (id_r+1) mod NREQ, state -> DONE.
- DONE:
  - done is high for exactly this cycle.
  - At the edge: done <= 0, state -> IDLE.
- Latency and throughput:
  - req seen in IDLE at cycle t: gnt high in cycle t+1, done and results valid in cycle t+2.
  - Maximum throughput is one comparison per 3 cycles.
- Requester protocol:
  - Hold req and operands stable until gnt rises. Operands are captured on that edge; later changes do not affect the result.
  - Drop req no later than the cycle done is high. If req is still high when the FSM returns to IDLE, it is treated as a new request.
- Request dropped while in CMP: the transaction still completes and done is still pulsed.
- Result registers hold their value until the next CMP->DONE edge.
- Exactly one of res_eq/res_gt/res_lt is 1 after the first completed transaction. All three are 0 only after reset.
- Comparison is unsigned. W=4 covers 0..15.
- Fairness: the served requester becomes lowest priority, so any continuously asserted req is served within NREQ transactions.
- req bits for a requester that is not granted are ignored outside IDLE. Simultaneous requests are resolved only by rr_ptr.

Decomposition:
- Shared package mag_cmp_pkg holds:
  - the state enum (IDLE/CMP/DONE);
  - default NREQ/W constants;
  - a function for round-robin winner selection from (req, rr_ptr).
- Sub-module mag_cmp_core: purely combinational W-bit unsigned comparator (a, b -> eq, gt, lt). It is instantiated once in the arbiter and is reusable elsewhere on the board.

Test Plan:
- Single request: reset, then req=0001 with opa[0]=5, opb[0]=5 -> gnt=0001 one cycle later, then done=0001 with res_eq=1, res_gt=0, res_lt=0, res_id=0 two cycles after req.
- Ordering checks on requester 2: A=12, B=3 -> res_gt=1, res_id=2. Then A=0, B=15 -> res_lt=1. Then A=15, B=15 -> res_eq=1.
- Contention: all four req held high, each with distinct operands -> grants in order 0,1,2,3,0. done spacing is 3 cycles and each result matches that requester's operands.
- Operand change after grant: requester 1 has A=9, B=4 at grant; change A to 2 during CMP -> result is still res_gt=1.
- Reset mid-operation: assert rst_n=0 in the CMP cycle -> next cycle all outputs 0, no done pulse, busy=0, and the next request from requester 3 is served first (rr_ptr=0 search reaches it).
- Idle hold: no req for 10 cycles after a res_lt result -> res_lt stays 1, gnt=0, done=0, busy=0.
